// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register map and default bus window.
package intr_pkg;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_MASK    = 2'd1,
        REG_EDGE    = 2'd2,
        REG_VECTOR  = 2'd3
    } reg_idx_e;

    localparam logic [27:0] BASE_ADR_DEFAULT = 28'hFFFFFFF;
    localparam int          IDX_W            = 5;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index priority encoder over the active interrupt vector.
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Wishbone-mapped interrupt controller: level/edge sources, mask, vector readout, registered irq_o.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          N_IRQ    = 8,
    parameter logic [27:0] BASE_ADR = BASE_ADR_DEFAULT
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic [31:2]      ADR_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic             CYC_I,
    input  logic             STB_I,
    input  logic             WE_I,
    output logic             ACK_O,
    input  logic [N_IRQ-1:0] irq_i,
    output logic             irq_o
);

    logic             sel_p0;
    logic             start_p0;
    logic             sel_p1;
    logic             wr_p0;
    logic             rd_p0;
    reg_idx_e         reg_idx;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_clear;

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] edge_mode;
    logic [N_IRQ-1:0] irq_d;
    logic             armed;

    logic [N_IRQ-1:0] wdat;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] edge_chg;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] active;
    logic [IDX_W-1:0] vec_idx;
    logic             vec_valid;
    logic [31:0]      rdata;
    logic             unused_dat;

    // Stage p0: decode. A transfer starts only on the first selected cycle.
    assign sel_p0   = CYC_I && STB_I && (ADR_I[31:4] == BASE_ADR);
    assign start_p0 = sel_p0 && !sel_p1;
    assign reg_idx  = reg_idx_e'(ADR_I[3:2]);
    assign wr_p0    = start_p0 && WE_I;
    assign rd_p0    = start_p0 && !WE_I;
    assign wr_mask  = wr_p0 && (reg_idx == REG_MASK);
    assign wr_edge  = wr_p0 && (reg_idx == REG_EDGE);
    assign wr_clear = wr_p0 && (reg_idx == REG_VECTOR);

    assign wdat       = DAT_I[N_IRQ-1:0];
    assign unused_dat = ^DAT_I;
    assign active     = pending & mask;

    intr_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req   (active),
        .idx   (vec_idx),
        .valid (vec_valid)
    );

    // Edge bits: a new rising edge beats a simultaneous CLEAR; a mode change drops the bit.
    always_comb begin
        rise        = armed ? (irq_i & ~irq_d) : '0;
        clr         = wr_clear ? wdat : '0;
        edge_chg    = wr_edge ? (wdat ^ edge_mode) : '0;
        pending_nxt = (edge_mode & (rise | (pending & ~clr))) | (~edge_mode & irq_i);
        pending_nxt = pending_nxt & ~edge_chg;
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_PENDING: rdata = 32'(pending);
            REG_MASK:    rdata = 32'(mask);
            REG_EDGE:    rdata = 32'(edge_mode);
            REG_VECTOR:  rdata = {vec_valid, 26'd0, vec_idx};
            default:     rdata = '0;
        endcase
    end

    // Stage p1: registered bus response and interrupt state.
    // sel_p1 resets high so a cycle left selected across reset is not acknowledged.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            sel_p1    <= 1'b1;
            ACK_O     <= 1'b0;
            DAT_O     <= '0;
            irq_o     <= 1'b0;
            pending   <= '0;
            mask      <= '0;
            edge_mode <= '0;
            irq_d     <= '0;
            armed     <= 1'b0;
        end else begin
            sel_p1    <= sel_p0;
            ACK_O     <= start_p0;
            DAT_O     <= rd_p0 ? rdata : '0;
            irq_o     <= |active;
            pending   <= pending_nxt;
            irq_d     <= irq_i;
            armed     <= 1'b1;
            if (wr_mask) begin
                mask <= wdat;
            end
            if (wr_edge) begin
                edge_mode <= wdat;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: vector table, directed corner sequences, randomized model check.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int          N      = 8;
    localparam logic [31:0] A_PEND = 32'hFFFFFFF0;
    localparam logic [31:0] A_MASK = 32'hFFFFFFF4;
    localparam logic [31:0] A_EDGE = 32'hFFFFFFF8;
    localparam logic [31:0] A_VEC  = 32'hFFFFFFFC;
    localparam logic [31:0] A_OUT  = 32'hFFFFFFE4;

    logic          CLK_I = 1'b0;
    logic          RST_NI;
    logic [31:2]   ADR_I;
    logic [31:0]   DAT_I;
    logic [31:0]   DAT_O;
    logic          CYC_I;
    logic          STB_I;
    logic          WE_I;
    logic          ACK_O;
    logic [N-1:0]  irq_i;
    logic          irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the randomized phase
    logic [N-1:0]  m_pend, m_mask, m_edge, m_prev;
    bit            m_armed;

    typedef struct {
        logic [7:0]  irq;
        logic [7:0]  mask;
        logic [31:0] pend;
        logic [31:0] vec;
        logic        irqo;
    } vec_t;

    vec_t tbl[6];

    intr_ctrl #(.N_IRQ(N)) dut (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .DAT_O  (DAT_O),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ACK_O  (ACK_O),
        .irq_i  (irq_i),
        .irq_o  (irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic idle();
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] data);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = addr[31:2];
        DAT_I = data;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        drive(addr, 1'b1, data);
        tick();
        chk("wr_ack", 32'(ACK_O), 32'd1);
        idle();
        tick();
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        drive(addr, 1'b0, 32'd0);
        tick();
        chk("rd_ack", 32'(ACK_O), 32'd1);
        data = DAT_O;
        idle();
        tick();
    endtask

    function automatic logic [31:0] m_read(input int r);
        logic [31:0] v;
        v = 32'd0;
        case (r)
            0: v = 32'(m_pend);
            1: v = 32'(m_mask);
            2: v = 32'(m_edge);
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i] && m_mask[i]) v = 32'h80000000 + 32'(i);
                end
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  rirq;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        logic        exp_ack, exp_irq, prev_sel;
        int          op, rsel;

        tbl[0] = '{8'h01, 8'h01, 32'h01, 32'h80000000, 1'b1};
        tbl[1] = '{8'h28, 8'hFF, 32'h28, 32'h80000003, 1'b1};
        tbl[2] = '{8'h28, 8'h20, 32'h28, 32'h80000005, 1'b1};
        tbl[3] = '{8'h80, 8'h7F, 32'h80, 32'h00000000, 1'b0};
        tbl[4] = '{8'h00, 8'hFF, 32'h00, 32'h00000000, 1'b0};
        tbl[5] = '{8'hC0, 8'hC0, 32'hC0, 32'h80000006, 1'b1};

        RST_NI = 1'b0;
        idle();
        ADR_I  = '0;
        DAT_I  = '0;
        irq_i  = '0;
        tick();
        tick();
        chk("rst_ack", 32'(ACK_O), 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_irq_o", 32'(irq_o), 32'd0);
        RST_NI = 1'b1;
        tick();
        bus_rd(A_MASK, rd);
        chk("rst_mask", rd, 32'd0);

        // Level-mode vector table
        for (int k = 0; k < 6; k++) begin
            bus_wr(A_MASK, 32'(tbl[k].mask));
            irq_i = tbl[k].irq;
            tick();
            tick();
            chk("tbl_irq_o", 32'(irq_o), 32'(tbl[k].irqo));
            bus_rd(A_PEND, rd);
            chk("tbl_pending", rd, tbl[k].pend);
            bus_rd(A_VEC, rd);
            chk("tbl_vector", rd, tbl[k].vec);
        end

        // Level latency: irq_o follows irq_i two edges later
        irq_i = '0;
        bus_wr(A_MASK, 32'h01);
        tick();
        irq_i = 8'h01;
        tick();
        chk("lvl_rise_1", 32'(irq_o), 32'd0);
        tick();
        chk("lvl_rise_2", 32'(irq_o), 32'd1);
        irq_i = 8'h00;
        tick();
        chk("lvl_fall_1", 32'(irq_o), 32'd1);
        tick();
        chk("lvl_fall_2", 32'(irq_o), 32'd0);

        // Edge capture, vector, clear
        bus_wr(A_EDGE, 32'h04);
        bus_wr(A_MASK, 32'h04);
        irq_i = 8'h04;
        tick();
        irq_i = 8'h00;
        tick();
        bus_rd(A_PEND, rd);
        chk("edge_pending", rd, 32'h04);
        bus_rd(A_VEC, rd);
        chk("edge_vector", rd, 32'h80000002);
        chk("edge_irq_o", 32'(irq_o), 32'd1);
        bus_wr(A_VEC, 32'h04);
        chk("clr_irq_o", 32'(irq_o), 32'd0);
        bus_rd(A_PEND, rd);
        chk("clr_pending", rd, 32'h00);

        // Set beats a simultaneous CLEAR
        bus_wr(A_EDGE, 32'h02);
        bus_wr(A_MASK, 32'h02);
        irq_i = 8'h02;
        drive(A_VEC, 1'b1, 32'h02);
        tick();
        chk("coll_ack", 32'(ACK_O), 32'd1);
        idle();
        irq_i = 8'h00;
        tick();
        bus_rd(A_PEND, rd);
        chk("coll_pending", rd, 32'h02);
        bus_wr(A_VEC, 32'h02);
        bus_rd(A_PEND, rd);
        chk("coll_cleared", rd, 32'h00);

        // Out-of-window select stays silent; in-window held strobe acks once
        drive(A_OUT, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("out_ack", 32'(ACK_O), 32'd0);
            chk("out_dat", DAT_O, 32'd0);
        end
        idle();
        tick();
        bus_wr(A_MASK, 32'h5A);
        drive(A_MASK, 1'b0, 32'd0);
        chk("hold_ack_pre", 32'(ACK_O), 32'd0);
        tick();
        chk("hold_ack_1", 32'(ACK_O), 32'd1);
        chk("hold_dat_1", DAT_O, 32'h5A);
        tick();
        chk("hold_ack_2", 32'(ACK_O), 32'd0);
        chk("hold_dat_2", DAT_O, 32'd0);
        tick();
        chk("hold_ack_3", 32'(ACK_O), 32'd0);
        idle();
        tick();

        // Asynchronous reset in the middle of an acknowledged read
        bus_wr(A_EDGE, 32'h00);
        bus_wr(A_MASK, 32'h01);
        irq_i = 8'h01;
        tick();
        tick();
        chk("prerst_irq_o", 32'(irq_o), 32'd1);
        drive(A_MASK, 1'b0, 32'd0);
        tick();
        chk("prerst_ack", 32'(ACK_O), 32'd1);
        #2 RST_NI = 1'b0;
        #1;
        chk("arst_ack", 32'(ACK_O), 32'd0);
        chk("arst_dat", DAT_O, 32'd0);
        chk("arst_irq_o", 32'(irq_o), 32'd0);
        tick();
        #2 RST_NI = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postrst_ack", 32'(ACK_O), 32'd0);
        end
        idle();
        tick();
        bus_rd(A_MASK, rd);
        chk("postrst_mask", rd, 32'd0);
        chk("postrst_irq_o", 32'(irq_o), 32'd0);

        // Randomized traffic against the reference model
        RST_NI = 1'b0;
        idle();
        irq_i = '0;
        tick();
        RST_NI  = 1'b1;
        m_pend  = '0;
        m_mask  = '0;
        m_edge  = '0;
        m_prev  = '0;
        m_armed = 1'b0;
        prev_sel = 1'b1;
        for (int c = 0; c < 500; c++) begin
            rirq = 8'($urandom);
            op   = prev_sel ? 0 : int'($urandom_range(0, 7));
            rsel = int'($urandom_range(0, 3));
            wdat = $urandom;
            irq_i = rirq;
            case (op)
                1: drive({28'hFFFFFFF, 2'(rsel), 2'b00}, 1'b0, 32'd0);
                2: drive(A_MASK, 1'b1, wdat);
                3: drive(A_EDGE, 1'b1, wdat);
                4: drive(A_VEC, 1'b1, wdat);
                5: drive(A_PEND, 1'b1, wdat);
                6: drive({28'hFFFFFFE, 2'(rsel), 2'b00}, 1'b0, 32'd0);
                7: drive({28'hFFFFFFE, 2'(rsel), 2'b00}, 1'b1, wdat);
                default: idle();
            endcase
            exp_ack = (op >= 1) && (op <= 5);
            exp_dat = (op == 1) ? m_read(rsel) : 32'd0;
            exp_irq = |(m_pend & m_mask);

            for (int i = 0; i < N; i++) begin
                if (op == 3 && wdat[i] != m_edge[i]) begin
                    m_pend[i] = 1'b0;
                end else if (m_edge[i]) begin
                    if (m_armed && rirq[i] && !m_prev[i]) m_pend[i] = 1'b1;
                    else if (op == 4 && wdat[i]) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = rirq[i];
                end
            end
            if (op == 2) m_mask = wdat[N-1:0];
            if (op == 3) m_edge = wdat[N-1:0];
            m_prev  = rirq;
            m_armed = 1'b1;

            tick();
            chk("rnd_ack", 32'(ACK_O), 32'(exp_ack));
            chk("rnd_irq_o", 32'(irq_o), 32'(exp_irq));
            if (!(op >= 2 && op <= 5)) chk("rnd_dat", DAT_O, exp_dat);
            prev_sel = exp_ack;
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter N_IRQ SHALL default to 8 and set the number of interrupt sources (1..32).
REQ-002 Parameter BASE_ADR SHALL default to 28'hFFFFFFF and be the ADR_I[31:4] decode value (window 0xFFFFFFF0-0xFFFFFFFC).
REQ-003 CLK_I  in  1  single clock; all state SHALL be rising-edge.
REQ-004 RST_NI  in  1  reset, asynchronous, active-low.
REQ-005 ADR_I  in  [31:2]  Wishbone word address.
REQ-006 DAT_I  in  32  Wishbone write data.
REQ-007 DAT_O  out  32  Wishbone read data, registered.
REQ-008 CYC_I, STB_I, WE_I  in  1 each  Wishbone cycle, strobe, write enable.
REQ-009 ACK_O  out  1  Wishbone acknowledge, registered.
REQ-010 irq_i  in  N_IRQ  interrupt sources; bit 0 is the timer's interrupt_o; synchronous to CLK_I.
REQ-011 irq_o  out  1  combined interrupt request to the CPU, registered.

Function
REQ-012 Select SHALL be CYC_I && STB_I && ADR_I[31:4]==BASE_ADR; register index = ADR_I[3:2].
REQ-013 Registers: 0 PENDING (RO), 1 MASK (RW, 1=enabled), 2 EDGE (RW, 1=edge mode), 3 VECTOR on read / CLEAR on write.
REQ-014 ACK_O SHALL assert exactly one cycle after a selected cycle's first cycle and deassert the next cycle, even if STB_I stays high (no back-to-back ACK without a STB_I low cycle or re-select).
REQ-015 DAT_O SHALL be valid in the ACK_O cycle; unused upper bits read 0; DAT_O = 0 when ACK_O low.
REQ-016 Writes SHALL take effect on the same edge that raises ACK_O; writes to PENDING SHALL be ignored.
REQ-017 irq_d SHALL hold irq_i delayed one cycle for edge detection.
REQ-018 Level-mode bit: PENDING[i] = irq_i[i] registered each cycle; CLEAR has no effect.
REQ-019 Edge-mode bit: PENDING[i] SHALL set on irq_i[i] && !irq_d[i] and hold until a CLEAR write with DAT_I[i]=1.
REQ-020 Set and clear in the same cycle for an edge bit: set SHALL win (pending remains 1).
REQ-021 VECTOR read: bit 31 = any (PENDING & MASK); bits [4:0] = lowest index i with PENDING[i]&MASK[i], 0 when none.
REQ-022 irq_o SHALL equal |(PENDING & MASK) delayed one cycle.
REQ-023 Changing EDGE[i] SHALL clear PENDING[i] on that edge.
REQ-024 Selected cycles with ADR_I outside the window SHALL produce no ACK_O (bus slave silent).

Reset
REQ-025 On RST_NI low, asynchronously: ACK_O=0, DAT_O=0, irq_o=0, PENDING=0, MASK=0, EDGE=0, irq_d=0.
REQ-026 A bus cycle in progress at reset SHALL be abandoned; no ACK_O after release until a new select.
REQ-027 Reset release SHALL not create a spurious edge: irq_d captures irq_i on the first clock after release before edge detection is enabled.

Structure
REQ-028 Register index constants (REG_PENDING..REG_VECTOR) and BASE_ADR default SHALL live in a shared package intr_pkg.
REQ-029 Lowest-index priority encoder SHALL be a sub-module intr_prio_enc (N_IRQ in, 5-bit index + valid out, combinational).

Verification
REQ-030 Reset: drive RST_NI low mid-cycle -> all outputs 0 immediately, no ACK_O after release.
REQ-031 Level: MASK=0x01, irq_i[0]=1 -> irq_o=1 two cycles later; irq_i[0]=0 -> irq_o=0 two cycles later.
REQ-032 Edge: EDGE=0x04, MASK=0x04, 1-cycle pulse on irq_i[2] -> PENDING reads 0x04, VECTOR 0x80000002; CLEAR write 0x04 -> PENDING 0, irq_o 0.
REQ-033 Priority: pending bits 3 and 5 both masked on -> VECTOR 0x80000003; MASK=0x20 -> VECTOR 0x80000005.
REQ-034 Collision: edge on irq_i[1] in same cycle as CLEAR write 0x02 -> PENDING[1] stays 1.
REQ-035 Bus: read at 0xFFFFFFE4 (outside window) -> no ACK_O; read MASK at 0xFFFFFFF4 -> ACK_O one cycle after select, single cycle, DAT_O = MASK.
